// File: rtl/line_buffer_reader.sv
// Purpose : walks a snapshotted GRID_W x GRID_W bitmap and presents each set bit as an (x,y) pixel.
// Latency : one cycle per clear bit, two per set bit when px_ready is high; read_done one cycle after DONE.
// Backpr. : px_valid/px_x/px_y hold stable while px_ready is low; the scan stalls in EMIT meanwhile.
//
// Ports:
//   clk, n_rst         system clock, asynchronous active-low reset
//   bla_done           start strobe; line_buffer is captured when it is seen in IDLE
//   line_buffer        bitmap, bit index = y*GRID_W + x
//   px_valid/px_ready  pixel handshake; px_x / px_y carry the coordinate
//   busy               high whenever the reader is not idle
//   read_done          single-cycle completion pulse
//   set_count          pixels accepted in the current or last scan
module line_buffer_reader #(
  parameter int GRID_W = 64
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                bla_done,
  input  logic [GRID_W*GRID_W-1:0]            line_buffer,
  input  logic                                px_ready,
  output logic                                px_valid,
  output logic [$clog2(GRID_W)-1:0]           px_x,
  output logic [$clog2(GRID_W)-1:0]           px_y,
  output logic                                busy,
  output logic                                read_done,
  output logic [$clog2(GRID_W*GRID_W):0]      set_count
);

  localparam int NPIX = GRID_W * GRID_W;
  localparam int CW   = $clog2(GRID_W);
  localparam int IW   = $clog2(NPIX);
  localparam int SW   = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NPIX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [IW-1:0]     index;
  logic [NPIX-1:0]   snap;

  // The snapshot carries no reset: its contents only matter after a capture,
  // and a capture always precedes the first SCAN.
  always_ff @(posedge clk) begin
    if (state == IDLE && bla_done) begin
      snap <= line_buffer;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      index     <= '0;
      set_count <= '0;
      px_valid  <= 1'b0;
      px_x      <= '0;
      px_y      <= '0;
      busy      <= 1'b0;
      read_done <= 1'b0;
    end else begin
      read_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bla_done) begin
            index     <= '0;
            set_count <= '0;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (snap[index]) begin
            // Index is row-major, so the low bits are x and the high bits are y.
            px_valid <= 1'b1;
            px_x     <= index[CW-1:0];
            px_y     <= index[2*CW-1:CW];
            state    <= EMIT;
          end else if (index == LAST_IDX) begin
            state <= DONE;
          end else begin
            index <= index + IW'(1);
          end
        end
        EMIT: begin
          if (px_ready) begin
            px_valid  <= 1'b0;
            set_count <= set_count + SW'(1);
            if (index == LAST_IDX) begin
              state <= DONE;
            end else begin
              index <= index + IW'(1);
              state <= SCAN;
            end
          end
        end
        DONE: begin
          // bla_done is deliberately not looked at here; a new scan must be
          // requested once the reader is back in IDLE.
          read_done <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_buffer_reader.sv
// Purpose : self-checking bench for line_buffer_reader using a queue of expected pixel indices.
// Latency : expected read_done cycle = 4097 + N*(1+hold) after the start edge.
// Backpr. : px_ready is withheld for a configurable number of valid cycles per pixel.
module tb_line_buffer_reader;

  logic          clk;
  logic          n_rst;
  logic          bla_done;
  logic [4095:0] line_buffer;
  logic          px_ready;
  logic          px_valid;
  logic [5:0]    px_x;
  logic [5:0]    px_y;
  logic          busy;
  logic          read_done;
  logic [12:0]   set_count;

  int vectors;
  int miscompares;
  int exp_q[$];

  line_buffer_reader #(.GRID_W(64)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .bla_done    (bla_done),
    .line_buffer (line_buffer),
    .px_ready    (px_ready),
    .px_valid    (px_valid),
    .px_x        (px_x),
    .px_y        (px_y),
    .busy        (busy),
    .read_done   (read_done),
    .set_count   (set_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive the bitmap and push every set bit, in ascending index order, as an expected pixel.
  task automatic load_buffer(input logic [4095:0] bm);
    line_buffer = bm;
    exp_q.delete();
    for (int i = 0; i < 4096; i++) begin
      if (bm[i]) exp_q.push_back(i);
    end
  endtask

  // bla_done is sampled at "edge 0"; returns just after that edge.
  task automatic start_scan();
    @(negedge clk);
    bla_done = 1'b1;
    @(posedge clk);
    #1;
    bla_done = 1'b0;
  endtask

  task automatic run_scan(input int hold, input bit mid_change);
    int n;
    int cyc;
    int done_cyc;
    int acc;
    int vcnt;
    int cur;
    n        = exp_q.size();
    cyc      = 0;
    done_cyc = -1;
    acc      = 0;
    vcnt     = 0;
    px_ready = (hold == 0);
    start_scan();
    while (done_cyc < 0 && cyc < 12000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) check("busy_start", busy, 1);
      if (mid_change && cyc == 100) begin
        line_buffer = '1;
        bla_done    = 1'b1;
      end else if (mid_change && cyc == 101) begin
        bla_done = 1'b0;
      end
      if (px_valid) begin
        check("busy_when_valid", busy, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_px", 1, 0);
        end else begin
          cur = exp_q[0];
          check("px_x", px_x, cur % 64);
          check("px_y", px_y, cur / 64);
        end
        vcnt++;
        px_ready = (vcnt > hold);
        if (px_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          acc++;
          vcnt = 0;
        end
      end else begin
        px_ready = (hold == 0);
      end
      if (read_done) done_cyc = cyc;
    end
    if (done_cyc < 0) check("timeout_read_done", 0, 1);
    check("read_done_cycle", done_cyc, 4097 + n * (1 + hold));
    check("set_count", set_count, n);
    check("acceptances", acc, n);
    check("queue_drained", exp_q.size(), 0);
    @(posedge clk);
    @(negedge clk);
    check("read_done_one_cycle", read_done, 0);
    check("busy_after_done", busy, 0);
    check("set_count_held", set_count, n);
    px_ready = 1'b1;
  endtask

  initial begin
    logic [4095:0] bm;
    int viol;
    int waited;
    vectors     = 0;
    miscompares = 0;
    n_rst       = 1'b0;
    bla_done    = 1'b0;
    px_ready    = 1'b1;
    line_buffer = '0;
    #2;
    check("rst_px_valid", px_valid, 0);
    check("rst_px_x", px_x, 0);
    check("rst_px_y", px_y, 0);
    check("rst_busy", busy, 0);
    check("rst_read_done", read_done, 0);
    check("rst_set_count", set_count, 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // All-zero bitmap.
    load_buffer('0);
    run_scan(0, 1'b0);

    // Corner bits only.
    bm = '0; bm[0] = 1'b1; bm[4095] = 1'b1;
    load_buffer(bm);
    run_scan(0, 1'b0);

    // Diagonal (0,0)-(23,23).
    bm = '0;
    for (int i = 0; i < 24; i++) bm[i*64 + i] = 1'b1;
    load_buffer(bm);
    run_scan(0, 1'b0);

    // Single pixel (1,1) with backpressure for 5 valid cycles.
    bm = '0; bm[65] = 1'b1;
    load_buffer(bm);
    run_scan(5, 1'b0);

    // Reset during EMIT.
    bm = '0; bm[65] = 1'b1; bm[200] = 1'b1;
    load_buffer(bm);
    px_ready = 1'b0;
    start_scan();
    waited = 0;
    while (!px_valid && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("pre_reset_valid", px_valid, 1);
    n_rst = 1'b0;
    #1;
    check("mid_rst_px_valid", px_valid, 0);
    check("mid_rst_px_x", px_x, 0);
    check("mid_rst_px_y", px_y, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_set_count", set_count, 0);
    @(negedge clk);
    n_rst = 1'b1;
    px_ready = 1'b1;
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (read_done || busy || px_valid) viol++;
    end
    check("idle_after_reset", viol, 0);

    // Fresh scan after reset, with the source bitmap rewritten and bla_done re-pulsed mid-scan.
    bm = '0; bm[10] = 1'b1; bm[3000] = 1'b1; bm[4095] = 1'b1;
    load_buffer(bm);
    run_scan(0, 1'b1);
    line_buffer = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
